// File: rtl/jtopl_lfo_pkg.sv
// Shared constants and types for the LFO decode slice.
//  - LFO count width, default widths for AM attenuation and F-number
//  - AM depth shifts (deep: tri>>1, shallow: tri>>3)
//  - PM position table: magnitude class and sign for each of the 8 LFO positions
//  - stage-1 pipeline record
package jtopl_lfo_pkg;

  localparam int LFOW     = 7;
  localparam int AMW_DEF  = 6;
  localparam int FNW_DEF  = 10;

  localparam int AM_SHIFT_DEEP    = 1;  // 0..31
  localparam int AM_SHIFT_SHALLOW = 3;  // 0..7

  // Vibrato magnitude relative to delta, per LFO position
  typedef enum logic [1:0] {
    PM_NONE = 2'd0,
    PM_HALF = 2'd1,
    PM_FULL = 2'd2
  } pm_mag_e;

  // Positions 0..7: 0, +1/2, +1, +1/2, 0, -1/2, -1, -1/2
  function automatic pm_mag_e pm_mag(input logic [2:0] pos);
    case (pos[1:0])
      2'd0:    pm_mag = PM_NONE;
      2'd2:    pm_mag = PM_FULL;
      default: pm_mag = PM_HALF;
    endcase
  endfunction

  // Second half of the LFO cycle pulls the F-number down
  function automatic logic pm_neg(input logic [2:0] pos);
    pm_neg = pos[2];
  endfunction

  typedef struct packed {
    logic [5:0] tri_v;   // triangle level 0..63
    logic [2:0] pos;     // LFO position for PM table
    logic [2:0] delta;   // vibrato step derived from F-number MSBs
    logic       dam;
    logic       am_en;
    logic       vib_en;
  } s1_t;

endpackage

// File: rtl/jtopl_lfo_pm.sv
// Vibrato offset lookup (combinational).
//  pos    in  3  LFO position (lfo value bits 6:4)
//  delta  in  3  vibrato step from F-number MSBs
//  vib_en in  1  slot vibrato enable
//  ofs    out 4  signed offset, -7..+7
module jtopl_lfo_pm
  import jtopl_lfo_pkg::*;
(
  input  logic [2:0]        pos,
  input  logic [2:0]        delta,
  input  logic              vib_en,
  output logic signed [3:0] ofs
);

  logic [3:0] mag;

  always_comb begin
    mag = 4'd0;
    case (pm_mag(pos))
      PM_HALF: mag = {2'b00, delta[2:1]};
      PM_FULL: mag = {1'b0, delta};
      default: mag = 4'd0;
    endcase
  end

  always_comb begin
    ofs = 4'sd0;
    if (vib_en) ofs = pm_neg(pos) ? -$signed(mag) : $signed(mag);
  end

endmodule

// File: rtl/jtopl_lfo_dec.sv
// LFO decoder: turns the free-running lfo_mod count into per-slot tremolo
// attenuation and vibrato-modulated F-number. Two registered stages, both
// advanced by cenop only.
//  clk, rst (sync, active-high), cenop (operator enable)
//  zero      first slot of frame; lfo_mod is snapshotted here
//  lfo_mod   7-bit LFO count
//  dam, dvb  AM / PM depth select
//  am_en, vib_en, fnum   per-slot inputs
//  am_att    tremolo attenuation (2 cenop later)
//  fnum_vib  F-number with vibrato applied, saturated (2 cenop later)
//  pm_ofs    signed vibrato offset that was applied
// Optional: define JTOPL_LFO_TEST_EN to add input lfo_tst, which forces the
// decoded LFO value to 0 and clears the snapshot.
module jtopl_lfo_dec
  import jtopl_lfo_pkg::*;
#(
  parameter int AMW = AMW_DEF,
  parameter int FNW = FNW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cenop,
  input  logic                     zero,
  input  logic [LFOW-1:0]          lfo_mod,
  input  logic                     dam,
  input  logic                     dvb,
  input  logic                     am_en,
  input  logic                     vib_en,
  input  logic [FNW-1:0]           fnum,
`ifdef JTOPL_LFO_TEST_EN
  input  logic                     lfo_tst,
`endif
  output logic [AMW-1:0]           am_att,
  output logic [FNW-1:0]           fnum_vib,
  output logic signed [3:0]        pm_ofs
);

  logic [LFOW-1:0] snap, v;
  s1_t             s1, s1_nxt;
  logic [FNW-1:0]  fnum1;

  // The zero slot bypasses the snapshot so the whole frame decodes one value
  always_comb begin
    v = zero ? lfo_mod : snap;
`ifdef JTOPL_LFO_TEST_EN
    if (lfo_tst) v = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) snap <= '0;
    else if (cenop) begin
`ifdef JTOPL_LFO_TEST_EN
      if (lfo_tst)   snap <= '0;
      else if (zero) snap <= lfo_mod;
`else
      if (zero) snap <= lfo_mod;
`endif
    end
  end

  // Stage 1: triangle fold, position and vibrato step
  always_comb begin
    s1_nxt.tri_v  = v[6] ? ~v[5:0] : v[5:0];
    s1_nxt.pos    = v[6:4];
    s1_nxt.delta  = dvb ? fnum[FNW-1 -: 3] : {1'b0, fnum[FNW-1 -: 2]};
    s1_nxt.dam    = dam;
    s1_nxt.am_en  = am_en;
    s1_nxt.vib_en = vib_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      fnum1 <= '0;
    end else if (cenop) begin
      s1    <= s1_nxt;
      fnum1 <= fnum;
    end
  end

  // Stage 2: AM depth, PM offset and saturating add
  logic [5:0]          am_d;
  logic signed [3:0]   ofs;
  logic signed [FNW+1:0] sum;
  logic [FNW-1:0]      fv_sat;

  always_comb begin
    am_d = s1.dam ? 6'(s1.tri_v >> AM_SHIFT_DEEP) : 6'(s1.tri_v >> AM_SHIFT_SHALLOW);
    if (!s1.am_en) am_d = '0;
  end

  jtopl_lfo_pm u_pm (
    .pos    (s1.pos),
    .delta  (s1.delta),
    .vib_en (s1.vib_en),
    .ofs    (ofs)
  );

  // Two guard bits: MSB flags underflow, next bit flags overflow
  always_comb begin
    sum = $signed({2'b00, fnum1}) + $signed({{(FNW-2){ofs[3]}}, ofs});
    if (sum[FNW+1])  fv_sat = '0;
    else if (sum[FNW]) fv_sat = '1;
    else             fv_sat = sum[FNW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      am_att   <= '0;
      fnum_vib <= '0;
      pm_ofs   <= '0;
    end else if (cenop) begin
      am_att   <= AMW'(am_d);
      fnum_vib <= fv_sat;
      pm_ofs   <= ofs;
    end
  end

endmodule

// File: tb/tb_jtopl_lfo_dec.sv
module tb_jtopl_lfo_dec;

  logic       clk = 0;
  logic       rst = 1;
  logic       cenop = 0, zero = 0, dam = 0, dvb = 0, am_en = 0, vib_en = 0;
  logic [6:0] lfo_mod = 0;
  logic [9:0] fnum = 0;
  logic [5:0] am_att;
  logic [9:0] fnum_vib;
  logic signed [3:0] pm_ofs;
`ifdef JTOPL_LFO_TEST_EN
  logic       lfo_tst = 0;
`endif

  int checks = 0, failures = 0;
  bit run = 0;

  always #5 clk = ~clk;

  jtopl_lfo_dec dut (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero), .lfo_mod(lfo_mod),
    .dam(dam), .dvb(dvb), .am_en(am_en), .vib_en(vib_en), .fnum(fnum),
`ifdef JTOPL_LFO_TEST_EN
    .lfo_tst(lfo_tst),
`endif
    .am_att(am_att), .fnum_vib(fnum_vib), .pm_ofs(pm_ofs)
  );

  typedef struct { int am; int fv; int ofs; } exp_t;

  // Direct arithmetic reading of the decode rules
  function automatic exp_t model(int v, bit d_am, bit d_vb, bit a_en, bit v_en, int fn);
    exp_t e;
    int tri_l, pos, delta, o;
    tri_l = (v >= 64) ? 63 - (v % 64) : v % 64;
    pos   = v / 16;
    delta = d_vb ? fn / 128 : fn / 256;
    e.am  = a_en ? (d_am ? tri_l / 2 : tri_l / 8) : 0;
    case (pos)
      1, 3:    o = delta / 2;
      2:       o = delta;
      5, 7:    o = -(delta / 2);
      6:       o = -delta;
      default: o = 0;
    endcase
    e.ofs = v_en ? o : 0;
    e.fv  = fn + e.ofs;
    if (e.fv < 0) e.fv = 0;
    if (e.fv > 1023) e.fv = 1023;
    return e;
  endfunction

  exp_t exp_cur = '{0, 0, 0}, exp_pipe = '{0, 0, 0};
  int frame_v = 0;

  always @(posedge clk) begin
    int v;
    if (rst) begin
      exp_cur = '{0, 0, 0}; exp_pipe = '{0, 0, 0}; frame_v = 0;
    end else if (cenop) begin
      v = zero ? int'(lfo_mod) : frame_v;
`ifdef JTOPL_LFO_TEST_EN
      if (lfo_tst) v = 0;
`endif
      exp_cur  = exp_pipe;
      exp_pipe = model(v, dam, dvb, am_en, vib_en, int'(fnum));
`ifdef JTOPL_LFO_TEST_EN
      if (lfo_tst) frame_v = 0; else if (zero) frame_v = int'(lfo_mod);
`else
      if (zero) frame_v = int'(lfo_mod);
`endif
    end
  end

  task automatic chk(string nm, int act, int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk("am_att", int'(am_att), exp_cur.am);
    chk("fnum_vib", int'(fnum_vib), exp_cur.fv);
    chk("pm_ofs", int'(pm_ofs), exp_cur.ofs);
  end

  // One enabled slot: inputs applied at negedge, sampled at next posedge
  task automatic slot(bit z, int lfo, bit d_am, bit d_vb, bit a_en, bit v_en, int fn);
    zero = z; lfo_mod = 7'(lfo); dam = d_am; dvb = d_vb;
    am_en = a_en; vib_en = v_en; fnum = 10'(fn); cenop = 1;
    @(negedge clk);
    cenop = 0;
  endtask

  initial begin
    // reset with cenop toggling
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      cenop = ~cenop; lfo_mod = 7'h50; am_en = 1; dam = 1; zero = 1;
      @(posedge clk); run = 1;
      @(negedge clk);
      chk("rst_am", int'(am_att), 0);
      chk("rst_fv", int'(fnum_vib), 0);
      chk("rst_pm", int'(pm_ofs), 0);
    end
    rst = 0; cenop = 0;
    @(negedge clk);

    // AM depth
    slot(1, 'h50, 1, 0, 1, 0, 'h100);
    slot(0, 'h11, 0, 0, 1, 0, 'h100);
    chk("am_deep", int'(am_att), 23);
    chk("am_fv", int'(fnum_vib), 'h100);
    slot(0, 'h22, 0, 0, 1, 0, 'h100);
    chk("am_shallow", int'(am_att), 5);

    // PM positive saturate, then negative full step
    slot(1, 'h20, 0, 1, 0, 1, 'h3FF);
    slot(0, 'h20, 0, 1, 0, 1, 'h100);
    chk("pm_sat_ofs", int'(pm_ofs), 7);
    chk("pm_sat_fv", int'(fnum_vib), 'h3FF);
    slot(1, 'h60, 0, 1, 0, 1, 'h383);
    chk("pm_half_fv", int'(fnum_vib), 'h102);
    slot(0, 'h60, 0, 1, 0, 1, 'h383);
    chk("pm_neg_ofs", int'(pm_ofs), -7);
    chk("pm_neg_fv", int'(fnum_vib), 'h37C);

    // snapshot holds across a mid-frame lfo change
    slot(1, 'h10, 1, 0, 1, 0, 'h40);
    slot(0, 'h60, 1, 0, 1, 0, 'h40);
    chk("snap_first", int'(am_att), 8);
    slot(0, 'h60, 1, 0, 1, 0, 'h40);
    chk("snap_mid", int'(am_att), 8);
    slot(1, 'h60, 1, 0, 1, 0, 'h40);
    chk("snap_last", int'(am_att), 8);
    slot(0, 'h10, 1, 0, 0, 0, 'h40);
    chk("snap_new", int'(am_att), 15);

    // cenop idle: hold, latency counted in cenop only
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_am", int'(am_att), 15);
    end
    slot(0, 'h10, 1, 0, 1, 0, 'h40);
    chk("hold_next", int'(am_att), 0);

`ifdef JTOPL_LFO_TEST_EN
    lfo_tst = 1;
    slot(1, 'h50, 1, 1, 1, 1, 'h200);
    slot(0, 'h50, 1, 1, 1, 1, 'h200);
    chk("tst_am", int'(am_att), 0);
    chk("tst_pm", int'(pm_ofs), 0);
    chk("tst_fv", int'(fnum_vib), 'h200);
    lfo_tst = 0;
`endif

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cenop   = ($urandom_range(0, 2) != 0);
      zero    = ($urandom_range(0, 17) == 0);
      lfo_mod = 7'($urandom);
      dam     = 1'($urandom); dvb = 1'($urandom);
      am_en   = 1'($urandom); vib_en = 1'($urandom);
      fnum    = 10'($urandom);
      rst     = ($urandom_range(0, 399) == 0);
`ifdef JTOPL_LFO_TEST_EN
      lfo_tst = ($urandom_range(0, 19) == 0);
`endif
      @(negedge clk);
    end
    rst = 0; cenop = 0;
    @(negedge clk);
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
